// File: rtl/demux_sweep_ctrl_pkg.sv
// Shared constants for the demux sweep controller: channel count, select width and FSM state codes.
// No logic; imported by the controller and its channel search helper.
// No flow control of its own.
package demux_sweep_ctrl_pkg;

    // Demux fan-out is fixed at four channels, so the select is two bits.
    localparam int N_CH  = 4;
    localparam int SEL_W = 2;

    // Sweep FSM state codes.
    localparam logic [1:0] ST_IDLE   = 2'd0;
    localparam logic [1:0] ST_DWELL  = 2'd1;
    localparam logic [1:0] ST_FINISH = 2'd2;

endpackage

// File: rtl/demux_sweep_ctrl_next_ch_find.sv
// Next-enabled-channel search: the lowest set mask bit strictly above cur, or the lowest set bit overall when from_start is high.
// Purely combinational; zero cycles.
// No flow control; found=0 means that no channel qualifies.
module next_ch_find
    import demux_sweep_ctrl_pkg::*;
(
    input  logic [N_CH-1:0]  mask,
    input  logic [SEL_W-1:0] cur,
    input  logic             from_start,
    output logic [SEL_W-1:0] nxt,
    output logic             found
);

    // Scan from the top down so that the last match written is the lowest qualifying channel.
    always_comb begin
        nxt   = '0;
        found = 1'b0;
        for (int i = N_CH - 1; i >= 0; i--) begin
            if (mask[i] && (from_start || (i > int'(cur)))) begin
                nxt   = SEL_W'(i);
                found = 1'b1;
            end
        end
    end

endmodule

// File: rtl/demux_sweep_ctrl.sv
// Demux sweep sequencer: steps sel through the enabled channels in ascending order, D cycles each, and gates data_in onto ent.
// A start at edge 0 gives busy in cycles 1..N*D and a single done pulse in cycle N*D+1.
// No backpressure: start is ignored unless the block is idle, and abort drops the sweep at the next edge.
module demux_sweep_ctrl
    import demux_sweep_ctrl_pkg::*;
#(
    parameter int DWELL_W = 8
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               start,
    input  logic               abort,
    input  logic [DWELL_W-1:0] dwell,
    input  logic [N_CH-1:0]    ch_mask,
    input  logic               data_in,
    output logic               ent,
    output logic [SEL_W-1:0]   sel,
    output logic               busy,
    output logic               done
);

    logic [1:0]         state;
    logic [SEL_W-1:0]   sel_q;
    logic [DWELL_W-1:0] cnt;
    logic [DWELL_W-1:0] dwell_q;
    logic [N_CH-1:0]    mask_q;

    logic [DWELL_W-1:0] eff_dwell;
    logic [N_CH-1:0]    srch_mask;
    logic               srch_from_start;
    logic [SEL_W-1:0]   srch_nxt;
    logic               srch_found;
    logic               last_cycle;

    // A zero dwell still serves each channel for one cycle.
    assign eff_dwell = (dwell == '0) ? DWELL_W'(1) : dwell;

    // The counter holds the cycles left on the current channel, including the present one.
    assign last_cycle = (cnt <= DWELL_W'(1));

    // While idle the search looks at the live mask for the first channel; during a sweep it uses the latched mask.
    always_comb begin
        srch_mask       = mask_q;
        srch_from_start = 1'b0;
        if (state == ST_IDLE) begin
            srch_mask       = ch_mask;
            srch_from_start = 1'b1;
        end
    end

    next_ch_find u_next_ch_find (
        .mask       (srch_mask),
        .cur        (sel_q),
        .from_start (srch_from_start),
        .nxt        (srch_nxt),
        .found      (srch_found)
    );

    // Sweep FSM, dwell counter and registered select; sel only moves on edges, so the demux never sees a glitching select.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state   <= ST_IDLE;
            sel_q   <= '0;
            cnt     <= '0;
            dwell_q <= '0;
            mask_q  <= '0;
        end else begin
            case (state)
                ST_IDLE: begin
                    // start wins over a simultaneous abort here: abort only acts on a running sweep.
                    if (start) begin
                        mask_q  <= ch_mask;
                        dwell_q <= eff_dwell;
                        if (srch_found) begin
                            state <= ST_DWELL;
                            sel_q <= srch_nxt;
                            cnt   <= eff_dwell;
                        end else begin
                            state <= ST_FINISH;
                        end
                    end
                end
                ST_DWELL: begin
                    if (abort) begin
                        state <= ST_IDLE;
                        sel_q <= '0;
                        cnt   <= '0;
                    end else if (last_cycle) begin
                        if (srch_found) begin
                            // Disabled channels in between are skipped without spending any cycles.
                            sel_q <= srch_nxt;
                            cnt   <= dwell_q;
                        end else begin
                            state <= ST_FINISH;
                            sel_q <= '0;
                            cnt   <= '0;
                        end
                    end else begin
                        cnt <= cnt - DWELL_W'(1);
                    end
                end
                ST_FINISH: begin
                    state <= ST_IDLE;
                end
                default: begin
                    state <= ST_IDLE;
                    sel_q <= '0;
                    cnt   <= '0;
                end
            endcase
        end
    end

    // Outputs decode directly from state, so an asynchronous reset clears them at once.
    always_comb begin
        busy = (state == ST_DWELL);
        done = (state == ST_FINISH);
        ent  = busy & data_in;
        sel  = busy ? sel_q : '0;
    end

endmodule

// File: tb/tb_demux_sweep_ctrl.sv
module tb_demux_sweep_ctrl;

    logic       clk;
    logic       rst;
    logic       start;
    logic       abort;
    logic [7:0] dwell;
    logic [3:0] ch_mask;
    logic       data_in;
    logic       ent;
    logic [1:0] sel;
    logic       busy;
    logic       done;

    int n_checks = 0;
    int n_err    = 0;

    demux_sweep_ctrl #(.DWELL_W(8)) dut (
        .clk     (clk),
        .rst     (rst),
        .start   (start),
        .abort   (abort),
        .dwell   (dwell),
        .ch_mask (ch_mask),
        .data_in (data_in),
        .ent     (ent),
        .sel     (sel),
        .busy    (busy),
        .done    (done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Runs one sweep from idle. The reference is the list of channels served, one entry per busy cycle,
    // built from the mask and effective dwell. abort_at = busy cycle (1-based) in which abort is raised, 0 = none.
    // dmode: 0 random data, 1 constant one, 2 toggling. poke: disturb dwell/ch_mask/start mid-sweep and
    // raise abort together with the accepted start.
    task automatic sweep(input logic [3:0] m, input logic [7:0] d, input int abort_at,
                         input int dmode, input bit poke);
        logic [1:0] q[$];
        int         dd;
        logic       di;
        dd = (d == 0) ? 1 : int'(d);
        for (int ch = 0; ch < 4; ch++)
            if (m[ch])
                for (int r = 0; r < dd; r++) q.push_back(2'(ch));

        data_in = 1'b1;
        start   = 1'b1;
        abort   = poke;
        ch_mask = m;
        dwell   = d;
        #1;
        chk("idle_busy", {7'd0, busy}, 8'd0);
        chk("idle_ent",  {7'd0, ent},  8'd0);
        chk("idle_sel",  {6'd0, sel},  8'd0);
        chk("idle_done", {7'd0, done}, 8'd0);
        @(posedge clk); #1;
        start = 1'b0;
        abort = 1'b0;

        for (int k = 0; k < q.size(); k++) begin
            case (dmode)
                0:       di = 1'($urandom % 2);
                1:       di = 1'b1;
                default: di = 1'(k % 2);
            endcase
            data_in = di;
            if (poke) begin
                ch_mask = 4'($urandom);
                dwell   = 8'($urandom);
            end
            #1;
            chk("dw_busy", {7'd0, busy}, 8'd1);
            chk("dw_sel",  {6'd0, sel},  {6'd0, q[k]});
            chk("dw_ent",  {7'd0, ent},  {7'd0, di});
            chk("dw_done", {7'd0, done}, 8'd0);
            start = poke ? 1'($urandom % 2) : 1'b0;
            abort = (k + 1 == abort_at);
            @(posedge clk); #1;
            start = 1'b0;
            if (abort) begin
                abort   = 1'b0;
                data_in = 1'b1;
                #1;
                chk("ab_busy", {7'd0, busy}, 8'd0);
                chk("ab_sel",  {6'd0, sel},  8'd0);
                chk("ab_ent",  {7'd0, ent},  8'd0);
                chk("ab_done", {7'd0, done}, 8'd0);
                @(posedge clk); #1;
                chk("ab_done2", {7'd0, done}, 8'd0);
                chk("ab_busy2", {7'd0, busy}, 8'd0);
                return;
            end
        end

        // Finish cycle: start and abort are both raised here and must have no effect.
        data_in = 1'b1;
        start   = 1'b1;
        abort   = 1'b1;
        #1;
        chk("fin_done", {7'd0, done}, 8'd1);
        chk("fin_busy", {7'd0, busy}, 8'd0);
        chk("fin_sel",  {6'd0, sel},  8'd0);
        chk("fin_ent",  {7'd0, ent},  8'd0);
        @(posedge clk); #1;
        start = 1'b0;
        abort = 1'b0;
        chk("post_done", {7'd0, done}, 8'd0);
        chk("post_busy", {7'd0, busy}, 8'd0);
        chk("post_sel",  {6'd0, sel},  8'd0);
    endtask

    initial begin
        logic [3:0] rm;
        logic [7:0] rd;
        int         len;
        int         ab;

        rst     = 1'b1;
        start   = 1'b0;
        abort   = 1'b0;
        data_in = 1'b1;
        ch_mask = 4'd0;
        dwell   = 8'd0;
        #3;
        chk("rst_sel",  {6'd0, sel},  8'd0);
        chk("rst_ent",  {7'd0, ent},  8'd0);
        chk("rst_busy", {7'd0, busy}, 8'd0);
        chk("rst_done", {7'd0, done}, 8'd0);
        #9;
        rst = 1'b0;
        @(posedge clk); #1;

        // Reset in the middle of a sweep: mask 1100, dwell 2 -> cycles 1,2 on ch2, 3,4 on ch3.
        start   = 1'b1;
        ch_mask = 4'b1100;
        dwell   = 8'd2;
        @(posedge clk); #1;
        start = 1'b0;
        @(posedge clk); #1;
        @(posedge clk); #1;
        chk("mid_busy", {7'd0, busy}, 8'd1);
        chk("mid_sel",  {6'd0, sel},  8'd3);
        #2;
        rst = 1'b1;
        #1;
        chk("arst_sel",  {6'd0, sel},  8'd0);
        chk("arst_ent",  {7'd0, ent},  8'd0);
        chk("arst_busy", {7'd0, busy}, 8'd0);
        chk("arst_done", {7'd0, done}, 8'd0);
        #1;
        rst = 1'b0;
        @(posedge clk); #1;
        chk("arst_done2", {7'd0, done}, 8'd0);
        chk("arst_busy2", {7'd0, busy}, 8'd0);

        // Directed sweeps.
        sweep(4'b1111, 8'd2, 0, 1, 1'b0);
        sweep(4'b1010, 8'd3, 0, 2, 1'b0);
        sweep(4'b0000, 8'd5, 0, 0, 1'b0);
        sweep(4'b0001, 8'd0, 0, 0, 1'b0);
        sweep(4'b1111, 8'd4, 3, 0, 1'b1);
        sweep(4'b1000, 8'd1, 1, 0, 1'b0);
        sweep(4'b0110, 8'd2, 4, 1, 1'b0);

        // Random sweeps with occasional aborts and mid-sweep disturbance.
        for (int t = 0; t < 30; t++) begin
            rm  = 4'($urandom);
            rd  = 8'($urandom_range(0, 5));
            len = $countones(rm) * ((rd == 0) ? 1 : int'(rd));
            ab  = 0;
            if (len > 0 && ($urandom % 4 == 0)) ab = $urandom_range(1, len);
            sweep(rm, rd, ab, int'($urandom % 3), 1'($urandom % 2));
        end

        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

endmodule
